// File: rtl/ping_sequencer_pkg.sv
// rtl/ping_sequencer_pkg.sv - shared types and constants for the phase-ping sequencer
package ping_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        LISTEN,
        ACCUM,
        DONE
    } state_t;

    // Default geometry: period P = 2^PERIOD_W cycles, N = 2^NPING_W pings per measurement
    localparam int DEF_PERIOD_W = 12;
    localparam int DEF_NPING_W  = 8;
    localparam int P            = 1 << DEF_PERIOD_W;
    localparam int N            = 1 << DEF_NPING_W;
    localparam int ACC_W        = DEF_PERIOD_W + DEF_NPING_W;

    // Timestamp of the last LISTEN cycle; the following cycle (P-1) is ACCUM
    localparam int LAST_LISTEN_K = P - 2;

    function automatic int last_listen_k(input int period_w);
        return (1 << period_w) - 2;
    endfunction

endpackage

// File: rtl/ping_sequencer_if.sv
// rtl/ping_sequencer_if.sv - control, echo and result handshake bundle of the ping sequencer
interface ping_sequencer_if #(
    parameter int PERIOD_W = 12,
    parameter int NPING_W  = 8
);
    localparam int ACC_W = PERIOD_W + NPING_W;

    logic               start;
    logic               abort;
    logic               cont;
    logic               tx_stb;
    logic               tx_busy;
    logic               rx_stb;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic [ACC_W-1:0]   res_first;
    logic [ACC_W-1:0]   res_last;
    logic [NPING_W:0]   res_hits;

    modport master (
        output start, abort, cont, tx_busy, rx_stb, res_ready,
        input  tx_stb, busy, res_valid, res_first, res_last, res_hits
    );

    modport slave (
        input  start, abort, cont, tx_busy, rx_stb, res_ready,
        output tx_stb, busy, res_valid, res_first, res_last, res_hits
    );

endinterface

// File: rtl/ping_sequencer_capture.sv
// rtl/ping_sequencer_capture.sv - per-ping timestamp counter with first/last echo capture
module ping_capture #(
    parameter int PERIOD_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic                rx_stb,
    input  logic                tx_busy,
    output logic [PERIOD_W-1:0] ts,
    output logic [PERIOD_W-1:0] first,
    output logic [PERIOD_W-1:0] last,
    output logic                got
);

    // clear marks the tx_stb cycle (k=0) so the first enabled cycle is k=1; echoes are masked while tx_busy
    always_ff @(posedge clk) begin
        if (rst) begin
            ts    <= '0;
            first <= '0;
            last  <= '0;
            got   <= 1'b0;
        end else if (clear) begin
            ts    <= PERIOD_W'(1);
            first <= '0;
            last  <= '0;
            got   <= 1'b0;
        end else if (en) begin
            ts <= ts + PERIOD_W'(1);
            if (rx_stb && !tx_busy) begin
                if (!got) begin
                    first <= ts;
                    got   <= 1'b1;
                end
                last <= ts;
            end
        end
    end

endmodule

// File: rtl/ping_sequencer.sv
// rtl/ping_sequencer.sv - ping burst FSM, echo timestamp accumulation and result handshake
module ping_sequencer
    import ping_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int NPING_W  = DEF_NPING_W
) (
    input  logic            clk,
    input  logic            rst,
    ping_sequencer_if.slave bus
);

    localparam int                  A_W    = PERIOD_W + NPING_W;
    localparam logic [PERIOD_W-1:0] LAST_K = PERIOD_W'(last_listen_k(PERIOD_W));

    state_t               state;
    logic [NPING_W-1:0]   ping_cnt;
    logic [A_W-1:0]       acc_first;
    logic [A_W-1:0]       acc_last;
    logic [NPING_W:0]     hits;
    logic                 tx_stb_q;
    logic                 busy_q;
    logic                 res_valid_q;

    logic [PERIOD_W-1:0]  ts;
    logic [PERIOD_W-1:0]  cap_first;
    logic [PERIOD_W-1:0]  cap_last;
    logic                 cap_got;

    ping_capture #(.PERIOD_W(PERIOD_W)) u_capture (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == FIRE),
        .en      (state == LISTEN),
        .rx_stb  (bus.rx_stb),
        .tx_busy (bus.tx_busy),
        .ts      (ts),
        .first   (cap_first),
        .last    (cap_last),
        .got     (cap_got)
    );

    // Sequencer FSM; tx_stb/busy/res_valid are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ping_cnt    <= '0;
            acc_first   <= '0;
            acc_last    <= '0;
            hits        <= '0;
            tx_stb_q    <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (bus.abort) begin
            state       <= IDLE;
            ping_cnt    <= '0;
            acc_first   <= '0;
            acc_last    <= '0;
            hits        <= '0;
            tx_stb_q    <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= FIRE;
                        tx_stb_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                FIRE: begin
                    tx_stb_q <= 1'b0;
                    state    <= LISTEN;
                end
                LISTEN: begin
                    if (ts == LAST_K) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (cap_got) begin
                        acc_first <= acc_first + A_W'(cap_first);
                        acc_last  <= acc_last + A_W'(cap_last);
                        hits      <= hits + (NPING_W+1)'(1);
                    end
                    ping_cnt <= ping_cnt + NPING_W'(1);
                    if (&ping_cnt) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b1;
                    end else begin
                        state    <= FIRE;
                        tx_stb_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        ping_cnt    <= '0;
                        acc_first   <= '0;
                        acc_last    <= '0;
                        hits        <= '0;
                        if (bus.cont) begin
                            state    <= FIRE;
                            tx_stb_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_stb    = tx_stb_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_first = acc_first;
    assign bus.res_last  = acc_last;
    assign bus.res_hits  = hits;

endmodule
